grant_lock_4: RTL and testbench

Grant-consumption stage placed directly downstream of the 4-way mutex arbiter. It:
- drives the arbiter's request inputs;
- synchronizes the arbiter's asynchronous grant outputs and checks them for stability and one-hotness;
- locks a single owner for a bounded tenure, then releases the arbiter cleanly.

Requesters see only the registered, glitch-free `gnt` vector and never see raw arbiter outputs.

---
 rtl/grant_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/grant_lock_4.sv | 125 ++++++++++++
 tb/tb_grant_lock_4.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/grant_pkg.sv
// Shared types and helpers for the grant-consumption stage behind the 4-way mutex arbiter.
package grant_pkg;
    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        OWNED   = 2'd2,
        RELEASE = 2'd3
    } grant_state_t;

    function automatic logic is_onehot4(input logic [NREQ-1:0] v);
        return (v != '0) && ((v & (v - NREQ'(1))) == '0);
    endfunction

    function automatic logic [1:0] enc4(input logic [NREQ-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchronizer for signals arriving asynchronously to clk.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/grant_lock_4.sv
// Locks one arbiter grant for a bounded tenure and hands requesters a clean registered grant.
//
// state   | meaning
// IDLE    | forwarding requests, waiting for a one-hot synchronized grant
// SETTLE  | candidate seen once; confirm it is still the granted one
// OWNED   | owner holds gnt, arbiter request pinned to owner, tenure counting
// RELEASE | requests withdrawn, waiting for the arbiter to drop its grant
module grant_lock_4 import grant_pkg::*; #(
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_in,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] arb_req,
    input  logic [NREQ-1:0] arb_gnt,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      owner,
    output logic            busy,
    output logic            timeout,
    output logic            err_multi
);
    localparam int             CW       = $clog2(HOLD_MAX);
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_MAX - 1);

    grant_state_t    state_q, state_d;
    logic [1:0]      cand_q, cand_d;
    logic [1:0]      owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] arb_req_q, arb_req_d;
    logic            timeout_q, timeout_d;
    logic            err_multi_q, err_multi_d;
    logic [NREQ-1:0] gnt_s;
    logic [NREQ-1:0] bo_mask;
    logic [NREQ-1:0] owner_oh;

    sync_2ff #(.W(NREQ)) u_gnt_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (arb_gnt),
        .q     (gnt_s)
    );

    assign owner_oh = NREQ'(1) << owner_q;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        err_multi_d = err_multi_q | ((gnt_s != '0) && !is_onehot4(gnt_s));
        bo_mask     = '0;

        case (state_q)
            IDLE: begin
                if (is_onehot4(gnt_s) && ((gnt_s & req_in) != '0)) begin
                    cand_d  = enc4(gnt_s);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (gnt_s == (NREQ'(1) << cand_q)) begin
                    owner_d = cand_q;
                    cnt_d   = '0;
                    state_d = OWNED;
                end else begin
                    state_d = IDLE;
                end
            end
            OWNED: begin
                cnt_d = cnt_q + CW'(1);
                if (done[owner_q] || !req_in[owner_q]) begin
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: begin
                if (gnt_s == '0) begin
                    state_d = IDLE;
                    // keep the last owner from immediately re-requesting on the way out
                    bo_mask = owner_oh;
                end
            end
            default: state_d = IDLE;
        endcase

        // arb_req is registered so the asynchronous arbiter never sees a decode glitch
        case (state_d)
            IDLE:    arb_req_d = req_in & ~bo_mask;
            SETTLE:  arb_req_d = arb_req_q;
            OWNED:   arb_req_d = NREQ'(1) << owner_d;
            default: arb_req_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            arb_req_q   <= '0;
            timeout_q   <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            arb_req_q   <= arb_req_d;
            timeout_q   <= timeout_d;
            err_multi_q <= err_multi_d;
        end
    end

    assign gnt       = (state_q == OWNED) ? owner_oh : '0;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign arb_req   = arb_req_q;
    assign timeout   = timeout_q;
    assign err_multi = err_multi_q;
endmodule

// File: tb/tb_grant_lock_4.sv
// Randomized transaction bench for grant_lock_4 with a tenure-level reference model.
module tb_grant_lock_4;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_in = '0;
    logic [3:0] done = '0;
    logic [3:0] arb_gnt = '0;
    logic [3:0] arb_req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic       err_multi;

    int n_chk = 0;
    int n_fail = 0;

    grant_lock_4 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .done      (done),
        .arb_req   (arb_req),
        .arb_gnt   (arb_gnt),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .timeout   (timeout),
        .err_multi (err_multi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Expected behaviour is derived per tenure: grant appears 3 edges after the
    // first sampling edge, lasts min(len, HOLD) cycles, times out only if len > HOLD.
    task automatic run_txn(input int idx, input int len, input bit by_done,
                           input int dly, input logic [3:0] extra);
        logic [3:0] oh;
        logic [3:0] held;
        int         n;
        int         ten;
        int         exp_ten;
        bit         exp_to;
        oh      = 4'b0001 << idx;
        exp_ten = (len > HOLD) ? HOLD : len;
        exp_to  = (len > HOLD);

        @(negedge clk);
        req_in  = oh | extra;
        arb_gnt = oh;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 12);
        chk("grant_latency", n, 4);
        chk("grant_vec", gnt, oh);
        chk("owner", owner, idx);
        chk("busy_owned", busy, 1);
        chk("arb_req_owned", arb_req, oh);

        ten = 0;
        while (gnt == oh && ten < HOLD + 8) begin
            ten++;
            if (ten == len) begin
                if (by_done) done = oh | (4'($urandom) & ~oh);
                else         req_in[idx] = 1'b0;
            end else begin
                done = 4'($urandom) & ~oh;
            end
            @(negedge clk);
            done = '0;
        end
        chk("tenure_len", ten, exp_ten);
        chk("timeout_pulse", timeout, exp_to);
        chk("arb_req_release", arb_req, 0);
        chk("busy_release", busy, 1);
        @(negedge clk);
        chk("timeout_single", timeout, 0);

        held = req_in;
        repeat (dly) @(negedge clk);
        arb_gnt = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 12);
        chk("release_to_idle", n, 3);
        chk("bo_mask_first_idle", arb_req, held & ~oh);
        @(negedge clk);
        chk("bo_mask_lifted", arb_req, held);
        req_in = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {gnt, arb_req, owner, busy, timeout, err_multi}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {gnt, arb_req, owner, busy, timeout, err_multi}, 0);

        // single grant / done release, then timeout and done-at-limit
        run_txn(2, 2, 1'b1, 0, 4'b0000);
        run_txn(1, HOLD + 10, 1'b1, 1, 4'b0000);
        run_txn(1, HOLD, 1'b1, 2, 4'b0000);
        run_txn(3, 1, 1'b0, 0, 4'b0101);

        // glitch: candidate 0 for one synchronized cycle, then the arbiter switches to 3
        @(negedge clk);
        req_in  = 4'b1001;
        arb_gnt = 4'b0001;
        @(negedge clk);
        arb_gnt = 4'b1000;
        chk("glitch_gnt_n1", gnt, 0);
        @(negedge clk);
        chk("glitch_gnt_n2", gnt, 0);
        @(negedge clk);
        chk("glitch_settle", busy, 1);
        chk("glitch_gnt_n3", gnt, 0);
        @(negedge clk);
        chk("glitch_abort_idle", busy, 0);
        chk("glitch_gnt_n4", gnt, 0);
        @(negedge clk);
        chk("glitch_resettle", busy, 1);
        @(negedge clk);
        chk("glitch_gnt_owner3", gnt, 4'b1000);
        chk("glitch_owner", owner, 3);
        done = 4'b1000;
        @(negedge clk);
        done = '0;
        chk("glitch_release_gnt", gnt, 0);
        arb_gnt = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 12);
        chk("glitch_back_idle", busy, 0);
        req_in = '0;
        repeat (2) @(negedge clk);

        // multi-hot grant sets sticky error
        req_in  = 4'b0011;
        arb_gnt = 4'b0011;
        repeat (3) @(negedge clk);
        chk("multi_err", err_multi, 1);
        chk("multi_gnt", gnt, 0);
        chk("multi_busy", busy, 0);
        arb_gnt = '0;
        req_in  = '0;
        repeat (4) @(negedge clk);
        chk("multi_sticky", err_multi, 1);
        #2 rst_n = 1'b0;
        #1 chk("multi_reset_clear", err_multi, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // randomized tenures
        for (int t = 0; t < 30; t++) begin
            int         idx;
            logic [3:0] extra;
            idx   = $urandom_range(3, 0);
            extra = 4'($urandom) & ~(4'b0001 << idx);
            run_txn(idx, $urandom_range(HOLD + 3, 1), 1'($urandom_range(1, 0)),
                    $urandom_range(3, 0), extra);
        end

        // asynchronous reset in the middle of a tenure
        @(negedge clk);
        req_in  = 4'b0010;
        arb_gnt = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 12);
        chk("rst_mid_owned", gnt, 4'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_gnt", gnt, 0);
        chk("rst_async_arb_req", arb_req, 0);
        chk("rst_async_busy", busy, 0);
        arb_gnt = '0;
        req_in  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_release", {gnt, arb_req, owner, busy, timeout, err_multi}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
